// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: transaction bus between the arbiter and the single-port memory
// Signals:
//   mem_req    arbiter -> memory  transaction active
//   mem_we     arbiter -> memory  1 = write
//   mem_addr   arbiter -> memory  transaction address
//   mem_wdata  arbiter -> memory  write data
//   mem_rdata  memory -> arbiter  read data, valid while mem_ready=1
//   mem_ready  memory -> arbiter  transaction completes this cycle
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and load/store
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   if_req, if_addr, flush         fetch request, PC, branch flush
//   if_instr, if_valid, freeze_if  fetched instruction, its one-cycle valid, IF/PC hold
//   dm_rd, dm_wr, dm_addr, dm_wdata  load/store request
//   dm_rdata, dm_done, freeze_pipe   load data, one-cycle completion, later-stage stall
//   mem                            memory transaction bus (master side)
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
    output logic              freeze_if,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              freeze_pipe,
    mem_port_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
    state_t state, state_n;
    logic stale, stale_n, stale_hit, fetch_done;
    logic done, f_cpl, d_cpl, grant, dm_ok, if_ok;
    // fetch_done / dm_done remember a completion at the previous edge, so a request
    // that was just served is not re-issued before the pipeline has advanced
    always_comb begin
        done      = (state != IDLE) & mem.mem_ready;
        f_cpl     = done & (state == FETCH);
        d_cpl     = done & (state == DATA);
        stale_hit = stale | (flush & (state == FETCH));
        dm_ok     = (dm_rd | dm_wr) & ~d_cpl & ~dm_done;
        if_ok     = if_req & ~f_cpl & ~fetch_done;
        grant     = (state == IDLE) | done;
        state_n   = grant ? (dm_ok ? DATA : if_ok ? FETCH : IDLE) : state;
        stale_n   = f_cpl ? 1'b0 : stale_hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            stale         <= 1'b0;
            fetch_done    <= 1'b0;
            if_valid      <= 1'b0;
            if_instr      <= '0;
            dm_done       <= 1'b0;
            dm_rdata      <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            state       <= state_n;
            stale       <= stale_n;
            fetch_done  <= f_cpl;
            if_valid    <= f_cpl & ~stale_hit;
            dm_done     <= d_cpl;
            mem.mem_req <= state_n != IDLE;
            if (f_cpl & ~stale_hit)
                if_instr <= mem.mem_rdata;
            if (d_cpl & ~mem.mem_we)
                dm_rdata <= mem.mem_rdata;
            if (grant) begin
                mem.mem_we <= dm_ok & dm_wr;
                if (dm_ok) begin
                    mem.mem_addr  <= dm_addr;
                    mem.mem_wdata <= dm_wdata;
                end else if (if_ok) begin
                    mem.mem_addr <= if_addr;
                end
            end
        end
    end
    assign freeze_if   = if_req & ~if_valid;
    assign freeze_pipe = (dm_rd | dm_wr) & ~dm_done;
endmodule
